// File: rtl/vga_pattern_gen_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_SHOW,
    ST_PENDING
  } state_e;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned BAR_WIDTH = 80;

  // Bar colours as {r,g,b} on/off flags, index 0 is the leftmost bar:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  // Bar number for a visible x, as a chain of x >= k*BAR_WIDTH comparators.
  function automatic logic [2:0] bar_index(input logic [9:0] x);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(x) >= i * BAR_WIDTH) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Timing bus from the 640x480 sync generator into the pattern generator.
// Syncs and video_on are combinational from the counters; x/y are registered
// and therefore lag video_on by one cycle.
interface vga_pattern_gen_if;
  logic       hsync_in;
  logic       vsync_in;
  logic       video_on_in;
  logic [9:0] x_in;
  logic [9:0] y_in;

  modport master (output hsync_in, vsync_in, video_on_in, x_in, y_in);
  modport slave  (input  hsync_in, vsync_in, video_on_in, x_in, y_in);
endinterface

// File: rtl/vga_pattern_gen_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, stability counter, rising-edge pulse.
// The debounced level follows the synced level only after it has differed for
// DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts it.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;

  // Synchronize, count stable cycles, update level and emit a press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      pulse_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        pulse_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: colour bars, grid, grey gradient, checkerboard.
// Syncs/de are delayed two cycles; pattern changes land on a frame boundary.
// Optional build macro: VGA_PATTERN_CROSSHAIR_EN adds a red centre crosshair.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int unsigned COLOR_W            = 4,
  parameter int unsigned FRAMES_PER_PATTERN = 120,
  parameter int unsigned DEBOUNCE_CYCLES    = 250000,
  parameter int unsigned INIT_PATTERN       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_pattern_gen_if.slave   vin,
  input  logic               btn_next,
  input  logic               auto_cycle,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               de_out,
  output logic [1:0]         pattern_idx
);

  localparam int unsigned FC_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_PATTERN - 1);
  localparam pattern_e PAT_RESET = pattern_e'(2'(INIT_PATTERN));

  logic hs_a_q, vs_a_q, de_a_q;
  logic hs_b_q, vs_b_q, de_b_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic [COLOR_W-1:0] r_d, g_d, b_d;

  state_e          state_q;
  pattern_e        pat_q;
  logic [FC_W-1:0] fcnt_q;
  logic            auto_req_q;
  logic            next_req;
  logic            frame_tick;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_next),
    .pulse_o(next_req)
  );

  // Stage B's vsync is stage A's previous value, so a falling edge of the
  // stage-A vsync is seen without an extra register.
  assign frame_tick = vs_b_q & ~vs_a_q;

  // Colour for the current x/y under the displayed pattern, blanked outside video.
  always_comb begin
    logic [2:0] bar_on;
    logic       white;
    bar_on = BAR_RGB[bar_index(vin.x_in)];
    white  = 1'b0;
    r_d    = '0;
    g_d    = '0;
    b_d    = '0;
    case (pat_q)
      PAT_BARS: begin
        r_d = {COLOR_W{bar_on[2]}};
        g_d = {COLOR_W{bar_on[1]}};
        b_d = {COLOR_W{bar_on[0]}};
      end
      PAT_GRID: begin
        white = (vin.x_in[4:0] == 5'd0) || (vin.y_in[4:0] == 5'd0) ||
                (vin.x_in == 10'(H_VISIBLE - 1)) || (vin.y_in == 10'(V_VISIBLE - 1));
        r_d = {COLOR_W{white}};
        g_d = {COLOR_W{white}};
        b_d = {COLOR_W{white}};
      end
      PAT_GRAD: begin
        r_d = vin.x_in[9 -: COLOR_W];
        g_d = vin.x_in[9 -: COLOR_W];
        b_d = vin.x_in[9 -: COLOR_W];
      end
      PAT_CHECK: begin
        white = vin.x_in[5] ^ vin.y_in[5];
        r_d = {COLOR_W{white}};
        g_d = {COLOR_W{white}};
        b_d = {COLOR_W{white}};
      end
      default: ;
    endcase
`ifdef VGA_PATTERN_CROSSHAIR_EN
    if ((vin.x_in == 10'(H_VISIBLE / 2)) || (vin.y_in == 10'(V_VISIBLE / 2))) begin
      r_d = '1;
      g_d = '0;
      b_d = '0;
    end
`endif
    if (!de_a_q) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  // Two-stage pipeline: stage A aligns syncs with x/y, stage B holds colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_a_q <= 1'b1;
      vs_a_q <= 1'b1;
      de_a_q <= 1'b0;
      hs_b_q <= 1'b1;
      vs_b_q <= 1'b1;
      de_b_q <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      hs_a_q <= vin.hsync_in;
      vs_a_q <= vin.vsync_in;
      de_a_q <= vin.video_on_in;
      hs_b_q <= hs_a_q;
      vs_b_q <= vs_a_q;
      de_b_q <= de_a_q;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  // Pattern FSM with frame counter; an advance at a frame tick also restarts
  // the auto interval, overriding that tick's counter step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SHOW;
      pat_q      <= PAT_RESET;
      fcnt_q     <= '0;
      auto_req_q <= 1'b0;
    end else begin
      auto_req_q <= 1'b0;
      if (!auto_cycle) begin
        fcnt_q <= '0;
      end else if (frame_tick) begin
        if (fcnt_q == FC_LAST) begin
          fcnt_q     <= '0;
          auto_req_q <= 1'b1;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end
      case (state_q)
        ST_SHOW: begin
          if (next_req || auto_req_q) state_q <= ST_PENDING;
        end
        ST_PENDING: begin
          if (frame_tick) begin
            pat_q   <= pattern_e'(2'(pat_q + 2'd1));
            fcnt_q  <= '0;
            state_q <= ST_SHOW;
          end
        end
        default: state_q <= ST_SHOW;
      endcase
    end
  end

  assign r_out       = r_q;
  assign g_out       = g_q;
  assign b_out       = b_q;
  assign hsync_out   = hs_b_q;
  assign vsync_out   = vs_b_q;
  assign de_out      = de_b_q;
  assign pattern_idx = pat_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized bench for vga_pattern_gen using short synthetic frames
// (two visible lines plus one vsync line) and a behavioural reference model.
module tb_vga_pattern_gen;

  localparam int COLOR_W = 4;
  localparam int FPP     = 2;
  localparam int DEB     = 16;
  localparam int INIT    = 3;
  localparam int H_VIS   = 640;
  localparam int H_TOT   = 680;
  localparam int HS_LO   = 648;
  localparam int HS_HI   = 664;
  localparam int PRESS   = 24;
  localparam int GLITCH  = 8;

  typedef struct {
    logic hs;
    logic vs;
    logic de;
    int   x;
    int   y;
  } smp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               btn_next = 1'b0;
  logic               auto_cycle = 1'b0;
  logic [COLOR_W-1:0] r_out, g_out, b_out;
  logic               hsync_out, vsync_out, de_out;
  logic [1:0]         pattern_idx;

  vga_pattern_gen_if vif ();

  vga_pattern_gen #(
    .COLOR_W           (COLOR_W),
    .FRAMES_PER_PATTERN(FPP),
    .DEBOUNCE_CYCLES   (DEB),
    .INIT_PATTERN      (INIT)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vin        (vif),
    .btn_next   (btn_next),
    .auto_cycle (auto_cycle),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .de_out     (de_out),
    .pattern_idx(pattern_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int   m_pat = INIT;
  int   m_fc = 0;
  bit   m_pending = 1'b0;
  smp_t cur, p1, p2, idle;
  int   last_x = 0;
  int   last_y = 0;
  int   specials[6] = '{32, 33, 479, 240, 0, 31};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected packed {r,g,b} for a visible pixel.
  function automatic int ref_rgb(input int x, input int y, input int pat);
    int full, r, g, b, bar, lvl;
    bit w;
    full = (1 << COLOR_W) - 1;
    r = 0; g = 0; b = 0; w = 1'b0;
    case (pat)
      0: begin
        bar = x / 80;
        case (bar)
          0: begin r = full; g = full; b = full; end
          1: begin r = full; g = full; end
          2: begin g = full; b = full; end
          3: begin g = full; end
          4: begin r = full; b = full; end
          5: begin r = full; end
          6: begin b = full; end
          default: ;
        endcase
      end
      1: begin
        w = (x % 32 == 0) || (y % 32 == 0) || (x == 639) || (y == 479);
        if (w) begin r = full; g = full; b = full; end
      end
      2: begin
        lvl = x / (1 << (10 - COLOR_W));
        r = lvl; g = lvl; b = lvl;
      end
      default: begin
        w = ((x / 32) % 2) != ((y / 32) % 2);
        if (w) begin r = full; g = full; b = full; end
      end
    endcase
    return (r << (2 * COLOR_W)) | (g << COLOR_W) | b;
  endfunction

  // Frame boundary: apply a pending advance, otherwise step the auto interval.
  task automatic model_tick();
    if (m_pending) begin
      m_pat     = (m_pat + 1) % 4;
      m_fc      = 0;
      m_pending = 1'b0;
    end else if (auto_cycle) begin
      if (m_fc == FPP - 1) begin
        m_fc      = 0;
        m_pending = 1'b1;
      end else begin
        m_fc++;
      end
    end else begin
      m_fc = 0;
    end
  endtask

  function automatic int pick_y();
    if ($urandom_range(0, 1) == 1) return specials[$urandom_range(0, 5)];
    return int'($urandom_range(0, 479));
  endfunction

  // One synthetic frame; press windows are in frame-cycle units, length 0 = none.
  task automatic run_frame(input bit auto_v, input int pa_s, input int pa_l,
                           input int pb_s, input int pb_l, input int rst_at);
    int ly[2];
    ly[0] = pick_y();
    ly[1] = pick_y();
    for (int vc = 0; vc < 3; vc++) begin
      for (int hc = 0; hc < H_TOT; hc++) begin
        int fidx;
        fidx = vc * H_TOT + hc;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if (fidx == 0) auto_cycle = auto_v;
        btn_next = ((fidx >= pa_s) && (fidx < pa_s + pa_l)) ||
                   ((fidx >= pb_s) && (fidx < pb_s + pb_l));
        cur.hs = !((hc >= HS_LO) && (hc < HS_HI));
        cur.vs = (vc != 2);
        cur.de = (vc < 2) && (hc < H_VIS);
        cur.x  = last_x;
        cur.y  = last_y;
        vif.hsync_in    = cur.hs;
        vif.vsync_in    = cur.vs;
        vif.video_on_in = cur.de;
        vif.x_in        = 10'(cur.x);
        vif.y_in        = 10'(cur.y);
        last_x = hc;
        last_y = (vc < 2) ? ly[vc] : 0;
        if (!cur.vs && p1.vs) model_tick();
        if (pa_l >= PRESS && fidx == pa_s + pa_l) m_pending = 1'b1;
        if (pb_l >= PRESS && fidx == pb_s + pb_l) m_pending = 1'b1;
        if (fidx == rst_at) begin
          #1 rst_n = 1'b0;
          #1;
          check("rst_hsync", 32'(hsync_out), 32'd1);
          check("rst_vsync", 32'(vsync_out), 32'd1);
          check("rst_de", 32'(de_out), 32'd0);
          check("rst_rgb", 32'({r_out, g_out, b_out}), 32'd0);
          check("rst_pattern", 32'(pattern_idx), 32'(INIT));
          m_pat = INIT; m_fc = 0; m_pending = 1'b0;
          cur = idle; p1 = idle; p2 = idle;
        end
        @(negedge clk);
        check("hsync_out", 32'(hsync_out), 32'(p2.hs));
        check("vsync_out", 32'(vsync_out), 32'(p2.vs));
        check("de_out", 32'(de_out), 32'(p2.de));
        check("rgb", 32'({r_out, g_out, b_out}),
              p2.de ? 32'(ref_rgb(p1.x, p1.y, m_pat)) : 32'd0);
        if (hc == 320) check("pattern_idx", 32'(pattern_idx), 32'(m_pat));
        p2 = p1;
        p1 = cur;
      end
    end
  endtask

  initial begin
    int s;
    idle.hs = 1'b1; idle.vs = 1'b1; idle.de = 1'b0; idle.x = 0; idle.y = 0;
    cur = idle; p1 = idle; p2 = idle;
    vif.hsync_in = 1'b1; vif.vsync_in = 1'b1; vif.video_on_in = 1'b0;
    vif.x_in = '0; vif.y_in = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hsync", 32'(hsync_out), 32'd1);
    check("reset_vsync", 32'(vsync_out), 32'd1);
    check("reset_de", 32'(de_out), 32'd0);
    check("reset_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    check("reset_pattern", 32'(pattern_idx), 32'(INIT));

    // Manual advances, glitch rejection, mid-line reset, double press.
    run_frame(1'b0, 0, 0, 0, 0, -1);
    s = int'($urandom_range(0, 500));
    run_frame(1'b0, s, PRESS, 0, 0, -1);
    s = int'($urandom_range(0, 500));
    run_frame(1'b0, s, GLITCH, 0, 0, -1);
    run_frame(1'b0, 0, 0, 0, 0, H_TOT + 300);
    s = int'($urandom_range(0, 500));
    run_frame(1'b0, s, PRESS, 0, 0, -1);
    s = int'($urandom_range(0, 400));
    run_frame(1'b0, s, PRESS, s + PRESS + 40, PRESS, -1);
    run_frame(1'b0, 0, 0, 0, 0, -1);
    for (int i = 0; i < 2; i++) begin
      s = int'($urandom_range(0, 500));
      run_frame(1'b0, s, PRESS, 0, 0, -1);
    end

    // Timed advance including the 3->0 wrap, with a random manual press.
    for (int i = 0; i < 10; i++) begin
      if (i == 6) begin
        s = int'($urandom_range(0, 500));
        run_frame(1'b1, s, PRESS, 0, 0, -1);
      end else begin
        run_frame(1'b1, 0, 0, 0, 0, -1);
      end
    end
    run_frame(1'b0, 0, 0, 0, 0, -1);
    run_frame(1'b0, 0, 0, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
